// File: rtl/wb_result_buffer.sv
// wb_result_buffer: in-order result FIFO between a functional unit and its writeback slot
module wb_result_buffer #(
  parameter int DEPTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     result_valid,
  input  logic [ID_WIDTH-1:0]      result_id,
  input  logic [DATA_WIDTH-1:0]    result_data,
  output logic                     result_ready,
  output logic                     done,
  output logic [ID_WIDTH-1:0]      id,
  output logic [DATA_WIDTH-1:0]    rd,
  input  logic                     ack,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] full_count = (aw+1)'(DEPTH);
  logic [ID_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
  logic [aw-1:0] wptr, rptr;
  logic [aw:0] count;
  logic push, pop;
  // ready looks only at the count, so a full buffer never passes a result through on ack
  assign result_ready = count != full_count;
  assign done = count != '0;
  assign occupancy = count;
  assign push = result_valid & result_ready;
  assign pop = ack & done;
  assign {id, rd} = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {result_id, result_data};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + aw'(push);
      rptr <= rptr + aw'(pop);
      count <= count + (aw+1)'(push) - (aw+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst && ack) ack_needs_head: assert (done) else $error("ack with no valid head");
endmodule

// File: tb/tb_wb_result_buffer.sv
// tb_wb_result_buffer: table-driven vectors plus hand-written reset/flush sequences
module tb_wb_result_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic result_valid = 1'b0;
  logic [2:0] result_id = '0;
  logic [31:0] result_data = '0;
  logic result_ready;
  logic done;
  logic [2:0] id;
  logic [31:0] rd;
  logic ack = 1'b0;
  logic [1:0] occupancy;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic v; logic [2:0] rid; logic [31:0] rdata; logic a; logic f;
    logic exp_done; logic [2:0] exp_id; logic [31:0] exp_rd; logic exp_ready; logic [1:0] exp_occ;
  } vec_t;
  vec_t vecs[$];

  wb_result_buffer #(.DEPTH(2), .DATA_WIDTH(32), .ID_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .result_valid(result_valid),
    .result_id(result_id), .result_data(result_data), .result_ready(result_ready),
    .done(done), .id(id), .rd(rd), .ack(ack), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [2:0] rid, input logic [31:0] rdata,
                              input logic a, input logic f, input logic ed, input logic [2:0] ei,
                              input logic [31:0] er, input logic ry, input logic [1:0] oc);
    vec_t x;
    x = '{v, rid, rdata, a, f, ed, ei, er, ry, oc};
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic v, input logic [2:0] rid, input logic [31:0] rdata,
                       input logic a, input logic f);
    @(negedge clk);
    result_valid = v;
    result_id = rid;
    result_data = rdata;
    ack = a;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single push then ack
    add(1, 3, 32'hDEADBEEF, 0, 0, 1, 3, 32'hDEADBEEF, 1, 1);
    add(0, 0, 0,            1, 0, 0, 0, 0,            1, 0);
    // fill, hold a blocked push, drain
    add(1, 1, 32'h11, 0, 0, 1, 1, 32'h11, 1, 1);
    add(1, 2, 32'h22, 0, 0, 1, 1, 32'h11, 0, 2);
    add(1, 5, 32'h55, 0, 0, 1, 1, 32'h11, 0, 2);
    add(1, 5, 32'h55, 1, 0, 1, 2, 32'h22, 1, 1);
    add(1, 5, 32'h55, 0, 0, 1, 2, 32'h22, 0, 2);
    add(0, 0, 0,      1, 0, 1, 5, 32'h55, 1, 1);
    add(0, 0, 0,      1, 0, 0, 0, 0,      1, 0);
    // simultaneous push and pop at occupancy 1
    add(1, 1, 32'h01, 0, 0, 1, 1, 32'h01, 1, 1);
    add(1, 4, 32'h44, 1, 0, 1, 4, 32'h44, 1, 1);
    add(0, 0, 0,      1, 0, 0, 0, 0,      1, 0);
    // wrap-around
    for (int i = 0; i < 7; i++) begin
      add(1, 3'(i), 32'(i * 16), 0, 0, 1, 3'(i), 32'(i * 16), 1, 1);
      add(0, 0, 0,               1, 0, 0, 0,     0,           1, 0);
    end
    // flush with push and ack in the same cycle
    add(1, 1, 32'h11, 0, 0, 1, 1, 32'h11, 1, 1);
    add(1, 2, 32'h22, 0, 0, 1, 1, 32'h11, 0, 2);
    add(1, 6, 32'h66, 1, 1, 0, 0, 0,      1, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0,      1, 0);
    add(1, 3, 32'h33, 0, 0, 1, 3, 32'h33, 1, 1);
    add(0, 0, 0,      1, 0, 0, 0, 0,      1, 0);

    #12;
    chk("reset_done", 32'(done), 0);
    chk("reset_ready", 32'(result_ready), 1);
    chk("reset_occ", 32'(occupancy), 0);
    @(negedge clk) rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_occ", 32'(occupancy), 0);

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].rid, vecs[k].rdata, vecs[k].a, vecs[k].f);
      chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
      chk($sformatf("v%0d_ready", k), 32'(result_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("v%0d_occ", k), 32'(occupancy), 32'(vecs[k].exp_occ));
      if (vecs[k].exp_done) begin
        chk($sformatf("v%0d_id", k), 32'(id), 32'(vecs[k].exp_id));
        chk($sformatf("v%0d_rd", k), rd, vecs[k].exp_rd);
      end
    end

    // asynchronous reset mid-cycle at occupancy 2
    drive(1, 1, 32'h11, 0, 0);
    drive(1, 2, 32'h22, 0, 0);
    chk("pre_rst_occ", 32'(occupancy), 2);
    @(negedge clk);
    result_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_occ", 32'(occupancy), 0);
    chk("async_rst_ready", 32'(result_ready), 1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    drive(1, 7, 32'h77, 0, 0);
    chk("post_rst_done", 32'(done), 1);
    chk("post_rst_id", 32'(id), 7);
    chk("post_rst_rd", rd, 32'h77);
    chk("post_rst_occ", 32'(occupancy), 1);
    drive(0, 0, 0, 1, 0);
    chk("post_rst_pop_done", 32'(done), 0);
    @(negedge clk) ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
